bmem_cpu_arbiter: RTL and testbench
===================================

Name: bmem_cpu_arbiter

Overview:
Memory-side arbiter of the CPU top. Connects the instruction-cache and data-cache line ports to the single banked-memory port. Issues line reads (single-cycle command, 4-beat return) and line writebacks (4-beat burst). Routes returning beats, tagged by raddr, to the requesting cache, so responses may return out of order.

Parameters:
ADDR_W, 32, byte address width
BEAT_W, 64, banked-memory data beat width
BURST, 4, beats per cache line (line = BURST*BEAT_W = 256 bits, 32-byte aligned)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_addr  in  ADDR_W  icache line address (low 5 bits ignored)
i_read  in  1  icache read request, level-held until i_resp
i_rdata  out  256  icache fill line
i_resp  out  1  one-cycle completion pulse
d_addr  in  ADDR_W  dcache line address
d_read  in  1  dcache read request, level-held until d_resp
d_write  in  1  dcache writeback request, level-held until d_resp (never together with d_read)
d_wdata  in  256  dcache writeback line
d_rdata  out  256  dcache fill line
d_resp  out  1  one-cycle completion pulse
bmem_addr  out  ADDR_W  memory command address, always 32-byte aligned
bmem_read  out  1  read command
bmem_write  out  1  write beat valid
bmem_wdata  out  BEAT_W  write beat
bmem_ready  in  1  memory accepts a command/beat this cycle
bmem_raddr  in  ADDR_W  address tag of the returning beat
bmem_rdata  in  BEAT_W  returning beat
bmem_rvalid  in  1  returning beat valid

Behaviour:
- All bmem_* and *_resp outputs are registered.
- Reset: all outputs 0, rdata regs 0, pending/issued flags cleared, RR pointer favours dcache. Beats arriving after reset for pre-reset requests are dropped.
- At most one outstanding request per client, so at most 2 outstanding reads in total.
- A client request is "new" when its req is high, the client is not pending, and its resp is not being pulsed this cycle.
- Issue FSM states: IDLE, RD_CMD, WR_BURST.
- IDLE: if any new request, grant one. Both new: round-robin, alternating from the last grant. Grant drives the command the next cycle.
- RD_CMD: bmem_read=1, bmem_addr={addr[31:5],5'b0} held until a cycle with bmem_ready=1. Then mark the client pending-read and return to IDLE.
- WR_BURST: bmem_write=1, bmem_addr constant, bmem_wdata = beat k = d_wdata[64k+:64], k=0..3. A beat is accepted only when bmem_ready=1; otherwise write, addr and beat are held. After beat 3 is accepted: d_resp=1 the next cycle (posted write), then IDLE.
- Return path, independent of the FSM: each rvalid beat whose raddr equals a pending client's aligned address is written into that client's line at its beat counter (0..3, LSB beat first). Beats of one line arrive in order but may be non-consecutive and interleaved with the other line.
- If both clients are pending on the same line address, each beat is delivered to both.
- Non-matching beats are ignored.
- After the 4th beat: *_rdata updated and *_resp=1 the next cycle. Pending clears. rdata holds until the next completion.
- Latency: req sampled at cycle t gives the command at t+1 at the earliest. Read resp follows the last beat by 1 cycle. Write resp follows the last accepted beat by 1 cycle.
- A client whose request is being pulsed resp must drop req or present a new one from the next cycle. The arbiter never re-issues on the resp cycle.
- Sync reset mid-burst aborts the burst: bmem_write=0 the next cycle.

Decomposition:
- Package bmem_pkg: ADDR_W/BEAT_W/BURST/LINE_W constants, line_t (256-bit), beat-count type, issue-state enum {IDLE, RD_CMD, WR_BURST}.
- One sub-module, bmem_line_assembler: per-client pending address, beat counter, line register, resp pulse. Instantiated twice.

Test Plan:
- i_read addr 0x0000_1234 alone: one bmem_read cycle at 0x0000_1220. Beats 0x11..,0x22..,0x33..,0x44.. with raddr 0x1220 → i_resp one cycle, i_rdata = {beat3,beat2,beat1,beat0}.
- d_write 0x8000_0040 with bmem_ready toggling 1,0,1,1,0,1: exactly 4 accepted beats in order d_wdata[63:0]..[255:192], addr constant → d_resp once, 1 cycle after the last accepted beat.
- i_read 0x100 and d_read 0x200 in the same cycle: d issued first, i on the next free cycle. Memory returns 0x100 beats before 0x200 beats → i_resp precedes d_resp, each with the correct data.
- Interleaved beats (A0,B0,A1,B1,A2,B2,A3,B3): both lines assembled correctly. Stray beat with raddr 0x9999_0000 is ignored.
- i and d both read 0x0000_0400: either one or two commands issued; both clients receive the identical line and each resp pulses exactly once.
- rst asserted mid write burst and with a read outstanding: outputs 0 the next cycle, late returning beats produce no resp.

Source files
------------

// File: rtl/bmem_pkg.sv
// Shared constants and types for the CPU-side banked-memory arbiter.
package bmem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BEAT_W = 64;
    localparam int unsigned BURST  = 4;
    localparam int unsigned LINE_W = BURST * BEAT_W;

    typedef logic [LINE_W-1:0]         line_t;
    typedef logic [$clog2(BURST)-1:0]  beat_cnt_t;

    typedef enum logic [1:0] {
        StIdle,
        StRdCmd,
        StWrBurst
    } issue_state_e;

    // Clear the byte offset within a cache line.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(LINE_W / 8 - 1);
    endfunction

endpackage

// File: rtl/bmem_line_assembler.sv
// Per-client read tracker: holds the pending line address, collects tagged beats
// into a fill buffer and publishes the completed line with a one-cycle resp pulse.
module bmem_line_assembler
    import bmem_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic              ext_done_i,
    input  logic              rvalid_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic [BEAT_W-1:0] rdata_i,
    output logic              pending_o,
    output line_t             line_o,
    output logic              resp_o
);

    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    beat_cnt_t         cnt_q, cnt_d;
    line_t             fill_q, fill_d;
    line_t             line_q, line_d;
    logic              resp_q, resp_d;
    logic              hit;

    assign hit = rvalid_i && pending_q && (raddr_i == addr_q);

    always_comb begin
        pending_d = pending_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        fill_d    = fill_q;
        line_d    = line_q;
        resp_d    = ext_done_i;
        if (start_i) begin
            pending_d = 1'b1;
            addr_d    = start_addr_i;
            cnt_d     = '0;
        end else if (hit) begin
            fill_d[32'(cnt_q) * BEAT_W +: BEAT_W] = rdata_i;
            cnt_d = cnt_q + beat_cnt_t'(1);
            if (cnt_q == beat_cnt_t'(BURST - 1)) begin
                pending_d = 1'b0;
                line_d    = fill_d;
                resp_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            fill_q    <= '0;
            line_q    <= '0;
            resp_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            fill_q    <= fill_d;
            line_q    <= line_d;
            resp_q    <= resp_d;
        end
    end

    assign pending_o = pending_q;
    assign line_o    = line_q;
    assign resp_o    = resp_q;

endmodule

// File: rtl/bmem_cpu_arbiter.sv
// Arbitrates icache/dcache line traffic onto one banked-memory port; read returns
// are steered back by address tag, so the two clients may complete out of order.
module bmem_cpu_arbiter
    import bmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    issue_state_e      state_q, state_d;
    logic              gnt_q, gnt_d;   // 1: dcache owns the current command
    logic              rr_q, rr_d;     // 1: dcache wins the next tie
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [BEAT_W-1:0] wdata_q, wdata_d;
    beat_cnt_t         wbeat_q, wbeat_d;
    logic              wr_done;
    logic              start_i, start_d;
    logic              i_pend, d_pend;
    logic              i_new, d_new;

    assign i_new = i_read && !i_pend && !i_resp;
    assign d_new = (d_read || d_write) && !d_pend && !d_resp;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        wbeat_d = wbeat_q;
        wr_done = 1'b0;
        start_i = 1'b0;
        start_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_new || d_new) begin
                    gnt_d  = (i_new && d_new) ? rr_q : d_new;
                    rr_d   = !gnt_d;
                    addr_d = line_align(gnt_d ? d_addr : i_addr);
                    if (gnt_d && d_write) begin
                        state_d = StWrBurst;
                        wr_d    = 1'b1;
                        wbeat_d = '0;
                        wdata_d = d_wdata[BEAT_W-1:0];
                    end else begin
                        state_d = StRdCmd;
                        rd_d    = 1'b1;
                    end
                end
            end
            StRdCmd: begin
                if (bmem_ready) begin
                    rd_d    = 1'b0;
                    state_d = StIdle;
                    start_i = !gnt_q;
                    start_d = gnt_q;
                end
            end
            StWrBurst: begin
                if (bmem_ready) begin
                    if (wbeat_q == beat_cnt_t'(BURST - 1)) begin
                        wr_d    = 1'b0;
                        wdata_d = '0;
                        wr_done = 1'b1;
                        state_d = StIdle;
                    end else begin
                        wbeat_d = wbeat_q + beat_cnt_t'(1);
                        wdata_d = d_wdata[32'(wbeat_d) * BEAT_W +: BEAT_W];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= 1'b0;
            rr_q    <= 1'b1;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            wbeat_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            wbeat_q <= wbeat_d;
        end
    end

    assign bmem_addr  = addr_q;
    assign bmem_read  = rd_q;
    assign bmem_write = wr_q;
    assign bmem_wdata = wdata_q;

    bmem_line_assembler u_icache_fill (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start_i),
        .start_addr_i (addr_q),
        .ext_done_i   (1'b0),
        .rvalid_i     (bmem_rvalid),
        .raddr_i      (bmem_raddr),
        .rdata_i      (bmem_rdata),
        .pending_o    (i_pend),
        .line_o       (i_rdata),
        .resp_o       (i_resp)
    );

    // Posted writeback completion shares the dcache resp register.
    bmem_line_assembler u_dcache_fill (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start_d),
        .start_addr_i (addr_q),
        .ext_done_i   (wr_done),
        .rvalid_i     (bmem_rvalid),
        .raddr_i      (bmem_raddr),
        .rdata_i      (bmem_rdata),
        .pending_o    (d_pend),
        .line_o       (d_rdata),
        .resp_o       (d_resp)
    );

endmodule

// File: tb/tb_bmem_cpu_arbiter.sv
// Self-checking bench for bmem_cpu_arbiter: table of single-client reads plus
// hand sequences for arbitration, write bursts, interleaving and reset.
module tb_bmem_cpu_arbiter;
    import bmem_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] i_addr, d_addr, bmem_addr, bmem_raddr;
    logic              i_read, i_resp, d_read, d_write, d_resp;
    logic              bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    logic [LINE_W-1:0] i_rdata, d_rdata, d_wdata;
    logic [BEAT_W-1:0] bmem_wdata, bmem_rdata;

    bmem_cpu_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_addr      (i_addr),
        .i_read      (i_read),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_addr      (d_addr),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              is_wr;
        logic [LINE_W-1:0] line;
    } d_exp_t;

    typedef struct {
        logic                           is_d;
        logic [ADDR_W-1:0]              addr;
        logic [ADDR_W-1:0]              cmd;
        int unsigned                    stall;
        logic [BURST-1:0][BEAT_W-1:0]   beats;
    } rd_vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int i_resp_cnt = 0, d_resp_cnt = 0, i_resp_cyc = 0, d_resp_cyc = 0;
    int rd_cycles = 0, wbeats = 0;
    int ei = 0, ed = 0;

    logic [LINE_W-1:0] exp_i_q[$];
    d_exp_t            exp_d_q[$];
    logic [BEAT_W-1:0] exp_wb_q[$];
    logic [ADDR_W-1:0] cmd_q[$];
    logic [ADDR_W-1:0] exp_waddr = '0;
    logic [LINE_W-1:0] last_d_line = '0;
    d_exp_t            de;

    task automatic chk(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory-side and client-side monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (bmem_read) rd_cycles++;
            if (bmem_read && bmem_ready) cmd_q.push_back(bmem_addr);
            if (bmem_write && bmem_ready) begin
                wbeats++;
                chk("wr_addr", bmem_addr, exp_waddr);
                chk("wr_beat_expected", exp_wb_q.size() > 0, 1);
                if (exp_wb_q.size() > 0) chk("wr_beat", bmem_wdata, exp_wb_q.pop_front());
            end
            if (i_resp) begin
                i_resp_cnt++;
                i_resp_cyc = cyc;
                chk("i_resp_expected", exp_i_q.size() > 0, 1);
                if (exp_i_q.size() > 0) chk("i_rdata", i_rdata, exp_i_q.pop_front());
            end
            if (d_resp) begin
                d_resp_cnt++;
                d_resp_cyc = cyc;
                chk("d_resp_expected", exp_d_q.size() > 0, 1);
                if (exp_d_q.size() > 0) begin
                    de = exp_d_q.pop_front();
                    if (de.is_wr) begin
                        chk("d_rdata_hold", d_rdata, last_d_line);
                    end else begin
                        chk("d_rdata", d_rdata, de.line);
                        last_d_line = de.line;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (i_resp) i_read = 1'b0;
        if (d_resp) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
    endtask

    task automatic wait_cmds(input int n, input string name);
        for (int k = 0; k < 40 && cmd_q.size() < n; k++) tick();
        chk(name, cmd_q.size(), n);
    endtask

    task automatic wait_resp(input int ti, input int td, input string name);
        for (int k = 0; k < 60 && (i_resp_cnt < ti || d_resp_cnt < td); k++) tick();
        repeat (3) tick();
        chk({name, "_i_cnt"}, i_resp_cnt, ti);
        chk({name, "_d_cnt"}, d_resp_cnt, td);
    endtask

    task automatic send_beat(input logic [ADDR_W-1:0] a, input logic [BEAT_W-1:0] b);
        bmem_raddr  = a;
        bmem_rdata  = b;
        bmem_rvalid = 1'b1;
        tick();
        bmem_rvalid = 1'b0;
    endtask

    function automatic rd_vec_t mk(input logic is_d, input logic [ADDR_W-1:0] a,
                                   input logic [ADDR_W-1:0] c, input int unsigned s,
                                   input logic [BEAT_W-1:0] b0, input logic [BEAT_W-1:0] b1,
                                   input logic [BEAT_W-1:0] b2, input logic [BEAT_W-1:0] b3);
        rd_vec_t v;
        v.is_d = is_d;
        v.addr = a;
        v.cmd = c;
        v.stall = s;
        v.beats[0] = b0;
        v.beats[1] = b1;
        v.beats[2] = b2;
        v.beats[3] = b3;
        return v;
    endfunction

    function automatic logic [LINE_W-1:0] pack_line(input logic [BEAT_W-1:0] b0,
            input logic [BEAT_W-1:0] b1, input logic [BEAT_W-1:0] b2,
            input logic [BEAT_W-1:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rd_vec_t           vecs[4];
        rd_vec_t           v;
        logic [LINE_W-1:0] la, lb, wline;
        logic [ADDR_W-1:0] c0, c1;
        logic [5:0]        pat;
        int                rd0, wb0, n;

        vecs[0] = mk(1'b0, 32'h0000_1234, 32'h0000_1220, 0, 64'h1111_1111_1111_1111,
                     64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        vecs[1] = mk(1'b1, 32'h0000_2008, 32'h0000_2000, 2, 64'hA0A0_0001_0000_0001,
                     64'hA0A0_0002_0000_0002, 64'hA0A0_0003_0000_0003, 64'hA0A0_0004_0000_0004);
        vecs[2] = mk(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFE0, 1, 64'hDEAD_BEEF_0000_0000,
                     64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0001);
        vecs[3] = mk(1'b1, 32'h8000_001F, 32'h8000_0000, 0, 64'h5555_AAAA_5555_AAAA,
                     64'h0F0F_0F0F_0F0F_0F0F, 64'hC3C3_C3C3_3C3C_3C3C, 64'h7777_6666_5555_4444);

        rst = 1'b1;
        i_addr = '0; i_read = 1'b0;
        d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        repeat (3) tick();

        chk("rst_bmem_read", bmem_read, 0);
        chk("rst_bmem_write", bmem_write, 0);
        chk("rst_bmem_addr", bmem_addr, 0);
        chk("rst_i_resp", i_resp, 0);
        chk("rst_d_resp", d_resp, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        rst = 1'b0;
        tick();

        // Simultaneous requests after reset: dcache wins, icache follows.
        la = pack_line(64'h0100_0000_0000_0000, 64'h0100_0000_0000_0001,
                       64'h0100_0000_0000_0002, 64'h0100_0000_0000_0003);
        lb = pack_line(64'h0200_0000_0000_0000, 64'h0200_0000_0000_0001,
                       64'h0200_0000_0000_0002, 64'h0200_0000_0000_0003);
        i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
        i_read = 1'b1; d_read = 1'b1;
        wait_cmds(2, "rr_cmds_seen");
        if (cmd_q.size() >= 2) begin
            chk("rr_first_cmd_d", cmd_q.pop_front(), 32'h0000_0200);
            chk("rr_second_cmd_i", cmd_q.pop_front(), 32'h0000_0100);
        end
        exp_i_q.push_back(la); ei++;
        exp_d_q.push_back('{is_wr: 1'b0, line: lb}); ed++;
        for (int k = 0; k < BURST; k++) send_beat(32'h0000_0100, la[k*BEAT_W +: BEAT_W]);
        for (int k = 0; k < BURST; k++) send_beat(32'h0000_0200, lb[k*BEAT_W +: BEAT_W]);
        wait_resp(ei, ed, "rr");
        chk("rr_order_i_before_d", i_resp_cyc < d_resp_cyc, 1);

        // Table of single-client reads with optional command back-pressure.
        for (int t = 0; t < 4; t++) begin
            v = vecs[t];
            bmem_ready = (v.stall == 0);
            rd0 = rd_cycles;
            if (v.is_d) begin
                d_addr = v.addr;
                d_read = 1'b1;
            end else begin
                i_addr = v.addr;
                i_read = 1'b1;
            end
            tick();
            chk("tbl_cmd_latency", bmem_read, 1);
            repeat (v.stall) tick();
            bmem_ready = 1'b1;
            wait_cmds(1, "tbl_cmd_seen");
            if (cmd_q.size() > 0) chk("tbl_cmd_addr", cmd_q.pop_front(), v.cmd);
            la = '0;
            for (int k = 0; k < BURST; k++) la[k*BEAT_W +: BEAT_W] = v.beats[k];
            if (v.is_d) begin
                exp_d_q.push_back('{is_wr: 1'b0, line: la});
                ed++;
            end else begin
                exp_i_q.push_back(la);
                ei++;
            end
            for (int k = 0; k < BURST; k++) begin
                send_beat(v.cmd, v.beats[k]);
                if (k == BURST - 1) chk("tbl_resp_latency", v.is_d ? d_resp : i_resp, 1);
            end
            wait_resp(ei, ed, "tbl");
            chk("tbl_cmd_cycles", rd_cycles - rd0, v.stall + 1);
        end

        // Writeback burst with ready pattern 1,0,1,1,0,1.
        wline = pack_line(64'hB0B0_0000_0000_0000, 64'hB1B1_1111_1111_1111,
                          64'hB2B2_2222_2222_2222, 64'hB3B3_3333_3333_3333);
        exp_waddr = 32'h8000_0040;
        for (int k = 0; k < BURST; k++) exp_wb_q.push_back(wline[k*BEAT_W +: BEAT_W]);
        exp_d_q.push_back('{is_wr: 1'b1, line: '0}); ed++;
        wb0 = wbeats;
        d_addr = 32'h8000_0040; d_wdata = wline; d_write = 1'b1;
        for (int k = 0; k < 20 && !bmem_write; k++) tick();
        chk("wr_started", bmem_write, 1);
        pat = 6'b101101;
        for (int p = 0; p < 6; p++) begin
            bmem_ready = pat[p];
            tick();
        end
        bmem_ready = 1'b1;
        chk("wr_resp_latency", d_resp, 1);
        chk("wr_write_dropped", bmem_write, 0);
        chk("wr_beat_count", wbeats - wb0, 4);
        wait_resp(ei, ed, "wr");

        // Interleaved returns plus a stray beat.
        la = pack_line(64'hA000_0000_0000_000A, 64'hA000_0000_0000_001A,
                       64'hA000_0000_0000_002A, 64'hA000_0000_0000_003A);
        lb = pack_line(64'hB000_0000_0000_000B, 64'hB000_0000_0000_001B,
                       64'hB000_0000_0000_002B, 64'hB000_0000_0000_003B);
        i_addr = 32'h0000_3000; d_addr = 32'h0000_4004;
        i_read = 1'b1; d_read = 1'b1;
        wait_cmds(2, "il_cmds_seen");
        if (cmd_q.size() >= 2) begin
            c0 = cmd_q.pop_front();
            c1 = cmd_q.pop_front();
            chk("il_cmd_pair", (c0 == 32'h0000_3000 && c1 == 32'h0000_4000) ||
                               (c0 == 32'h0000_4000 && c1 == 32'h0000_3000), 1);
        end
        exp_i_q.push_back(la); ei++;
        exp_d_q.push_back('{is_wr: 1'b0, line: lb}); ed++;
        for (int k = 0; k < BURST; k++) begin
            send_beat(32'h0000_3000, la[k*BEAT_W +: BEAT_W]);
            send_beat(32'h0000_4000, lb[k*BEAT_W +: BEAT_W]);
            if (k == 1) send_beat(32'h9999_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        wait_resp(ei, ed, "il");

        // Both clients on the same line.
        la = pack_line(64'h0400_0000_0000_0000, 64'h0400_1111_0000_0001,
                       64'h0400_2222_0000_0002, 64'h0400_3333_0000_0003);
        i_addr = 32'h0000_0400; d_addr = 32'h0000_041C;
        i_read = 1'b1; d_read = 1'b1;
        wait_cmds(1, "same_cmd_seen");
        repeat (8) tick();
        n = cmd_q.size();
        chk("same_cmd_count", n >= 1 && n <= 2, 1);
        while (cmd_q.size() > 0) chk("same_cmd_addr", cmd_q.pop_front(), 32'h0000_0400);
        exp_i_q.push_back(la); ei++;
        exp_d_q.push_back('{is_wr: 1'b0, line: la}); ed++;
        for (int k = 0; k < BURST; k++) send_beat(32'h0000_0400, la[k*BEAT_W +: BEAT_W]);
        wait_resp(ei, ed, "same");
        for (int k = 0; k < BURST; k++) send_beat(32'h0000_0400, ~la[k*BEAT_W +: BEAT_W]);
        wait_resp(ei, ed, "same_dup");
        chk("same_no_reissue", cmd_q.size(), 0);

        // Reset with a read outstanding and a write burst stalled mid-way.
        i_addr = 32'h0000_5000; i_read = 1'b1;
        wait_cmds(1, "rst_rd_cmd_seen");
        if (cmd_q.size() > 0) chk("rst_rd_cmd_addr", cmd_q.pop_front(), 32'h0000_5000);
        bmem_ready = 1'b0;
        exp_waddr = 32'h0000_6000;
        d_addr = 32'h0000_6000; d_wdata = wline; d_write = 1'b1;
        for (int k = 0; k < 20 && !bmem_write; k++) tick();
        chk("rst_wr_started", bmem_write, 1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_bmem_write", bmem_write, 0);
        chk("rst_mid_bmem_read", bmem_read, 0);
        chk("rst_mid_bmem_addr", bmem_addr, 0);
        chk("rst_mid_bmem_wdata", bmem_wdata, 0);
        chk("rst_mid_i_rdata", i_rdata, 0);
        chk("rst_mid_d_rdata", d_rdata, 0);
        exp_i_q.delete();
        exp_d_q.delete();
        exp_wb_q.delete();
        last_d_line = '0;
        i_read = 1'b0; d_write = 1'b0; bmem_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < BURST; k++) send_beat(32'h0000_5000, 64'h5000_0000_0000_0000 + k);
        wait_resp(ei, ed, "rst_late");
        chk("rst_late_i_rdata", i_rdata, 0);
        chk("rst_no_cmds", cmd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
